// File: rtl/gen_fifo_defines_pkg.sv
// Shared definitions for the generator FIFO read side: FSM state encoding,
// skid buffer depth and statistics counter width.
package gen_fifo_defines_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_DRAIN,
    RD_DONE
  } rd_state_t;

  localparam int SKID_DEPTH = 2;
  localparam int STATS_W    = 16;

endpackage

// File: rtl/gen_fifo_skid_buf.sv
// Two-entry FIFO-ordered skid buffer. It catches FIFO read data arriving one
// cycle after the pop, so backpressure never drops or duplicates a sample.
// The caller guarantees no write when full and no read when empty.
module gen_fifo_skid_buf
  import gen_fifo_defines_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;

  // Storage, pointers and occupancy; flush empties the buffer like reset
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/gen_fifo_reader.sv
// Read side of the generator FIFO: drains one burst of burst_len_i samples per
// accepted start_i and presents them on a valid/ready interface.
// Optional feature: define GEN_FIFO_RD_STATS_EN to add underflow_cnt_o, a
// saturating count of cycles spent waiting on an empty FIFO mid-burst.
module gen_fifo_reader
  import gen_fifo_defines_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clrh,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      burst_len_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o
`ifdef GEN_FIFO_RD_STATS_EN
  ,
  output logic [STATS_W-1:0]    underflow_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  rd_state_t        state;
  logic [CNT_W-1:0] rd_left;
  logic [CNT_W-1:0] tx_left;
  logic             inflight;
  logic [1:0]       occ;
  logic             xfer;
  logic [2:0]       committed;
  logic             drain_empty;

  assign valid_o = (occ != 2'd0);
  assign xfer    = valid_o && ready_i;

  // Slots already claimed after this cycle: buffered + in flight, less the
  // entry leaving now. Crediting the departing entry keeps 1 sample/cycle.
  assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};

  assign fifo_rd_o = (state == RD_READ) && !fifo_empty_i &&
                     (rd_left != '0) && (committed < 3'd2);

  // The burst is finished once nothing is in flight and the buffer empties now
  assign drain_empty = !inflight && ((occ == 2'd0) || ((occ == 2'd1) && xfer));

  gen_fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .flush  (clrh),
    .wr_en  (inflight),
    .wr_data(fifo_data_i),
    .rd_en  (xfer),
    .head   (data_o),
    .occ    (occ)
  );

  // Burst FSM with read/transfer counters and registered busy/done flags
  always_ff @(posedge clk) begin
    if (rst || clrh) begin
      state    <= RD_IDLE;
      rd_left  <= '0;
      tx_left  <= '0;
      inflight <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      inflight <= fifo_rd_o;
      if (fifo_rd_o) begin
        rd_left <= rd_left - CNT_ONE;
      end
      if (xfer && (tx_left != '0)) begin
        tx_left <= tx_left - CNT_ONE;
      end
      case (state)
        RD_IDLE: begin
          if (start_i) begin
            rd_left <= burst_len_i;
            tx_left <= burst_len_i;
            if (burst_len_i != '0) begin
              state  <= RD_READ;
              busy_o <= 1'b1;
            end else begin
              state  <= RD_DONE;
              done_o <= 1'b1;
            end
          end
        end
        RD_READ: begin
          if (fifo_rd_o && (rd_left == CNT_ONE)) begin
            state <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (drain_empty) begin
            state  <= RD_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        RD_DONE: begin
          state  <= RD_IDLE;
          done_o <= 1'b0;
        end
        default: begin
          state  <= RD_IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef GEN_FIFO_RD_STATS_EN
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + STATS_W'(1);
  endfunction

  // Starvation counter; survives start_i so it accumulates across bursts
  always_ff @(posedge clk) begin
    if (rst || clrh) begin
      underflow_cnt_o <= '0;
    end else if ((state == RD_READ) && fifo_empty_i && (rd_left != '0)) begin
      underflow_cnt_o <= sat_inc(underflow_cnt_o);
    end
  end
`endif

endmodule
